// File: rtl/doa_pkg.sv
// Shared types and helpers for the direction-of-arrival event capture block.
package doa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_REPORT,
    ST_HOLD
  } doa_state_t;

  localparam int MAX_CH = 8;

  // Delay value for a channel that never arrived within the window; slice to DLY_W.
  localparam logic [31:0] DLY_NONE = '1;

  function automatic logic [2:0] lowest_set(input logic [MAX_CH-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/doa_edge_detect.sv
// Two-register input stage: registers the detection levels and flags 0->1 transitions.
module doa_edge_detect #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] detected_i,
  output logic [NUM_CH-1:0] rise_o
);

  logic [NUM_CH-1:0] d_q;
  logic [NUM_CH-1:0] d_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q  <= '0;
      d_q2 <= '0;
    end else begin
      d_q  <= detected_i;
      d_q2 <= d_q;
    end
  end

  assign rise_o = d_q & ~d_q2;

endmodule

// File: rtl/doa_event_capture.sv
// Timestamps per-channel detection rises into one DOA record per event, hands it off
// over valid/ready, then ignores echoes for HOLDOFF cycles.
module doa_event_capture
  import doa_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DLY_W   = 12,
  parameter int WINDOW  = 2000,
  parameter int HOLDOFF = 5000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       detected,
  input  logic                    enable,
  output logic                    doa_valid,
  input  logic                    doa_ready,
  output logic [CH_W-1:0]         first_ch,
  output logic [NUM_CH*DLY_W-1:0] delay,
  output logic [NUM_CH-1:0]       ch_mask,
  output logic                    partial,
  output logic                    busy
);

  logic [NUM_CH-1:0] rise;

  doa_edge_detect #(
    .NUM_CH(NUM_CH)
  ) u_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .detected_i(detected),
    .rise_o    (rise)
  );

  doa_state_t             state_q;
  logic [DLY_W-1:0]       cnt_q;
  logic [15:0]            hold_q;
  logic                   doa_valid_q;
  logic [CH_W-1:0]        first_ch_q;
  logic [NUM_CH*DLY_W-1:0] delay_q;
  logic [NUM_CH-1:0]      ch_mask_q;
  logic                   partial_q;
  logic                   busy_q;

  logic [DLY_W-1:0]  cnt_d;
  logic [NUM_CH-1:0] cap_new;
  logic [NUM_CH-1:0] mask_d;
  logic [MAX_CH-1:0] rise_ext;

  // cnt_d is the delay of a rise seen this cycle: the cycle after the trigger counts as 1.
  always_comb begin
    cnt_d    = cnt_q + DLY_W'(1);
    cap_new  = rise & ~ch_mask_q;
    mask_d   = ch_mask_q | cap_new;
    rise_ext = '0;
    rise_ext[NUM_CH-1:0] = rise;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      doa_valid_q <= 1'b0;
      first_ch_q  <= '0;
      delay_q     <= '0;
      ch_mask_q   <= '0;
      partial_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && |rise) begin
            state_q    <= ST_CAPTURE;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            first_ch_q <= CH_W'(lowest_set(rise_ext));
            ch_mask_q  <= rise;
            partial_q  <= 1'b0;
            // Pre-load the sentinel so channels that never arrive need no fix-up later.
            for (int i = 0; i < NUM_CH; i++) begin
              delay_q[i*DLY_W +: DLY_W] <= rise[i] ? '0 : DLY_NONE[DLY_W-1:0];
            end
          end
        end
        ST_CAPTURE: begin
          cnt_q     <= cnt_d;
          ch_mask_q <= mask_d;
          for (int i = 0; i < NUM_CH; i++) begin
            if (cap_new[i]) delay_q[i*DLY_W +: DLY_W] <= cnt_d;
          end
          if (&mask_d || cnt_d == DLY_W'(WINDOW)) begin
            state_q     <= ST_REPORT;
            doa_valid_q <= 1'b1;
            partial_q   <= ~&mask_d;
          end
        end
        ST_REPORT: begin
          if (doa_ready) begin
            doa_valid_q <= 1'b0;
            if (HOLDOFF == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_HOLD;
              hold_q  <= 16'(HOLDOFF);
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == 16'd1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign doa_valid = doa_valid_q;
  assign first_ch  = first_ch_q;
  assign delay     = delay_q;
  assign ch_mask   = ch_mask_q;
  assign partial   = partial_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_doa_event_capture.sv
// Scoreboard bench for doa_event_capture: expected records are queued at stimulus time
// and compared at each valid/ready handshake.
module tb_doa_event_capture;

  localparam int NUM_CH = 4;
  localparam int DLY_W  = 12;
  localparam int W      = 30;
  localparam int H      = 100;
  localparam int NONE   = 4095;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0]       detected;
  logic                    enable;
  logic                    doa_valid;
  logic                    doa_ready;
  logic [1:0]              first_ch;
  logic [NUM_CH*DLY_W-1:0] delay;
  logic [NUM_CH-1:0]       ch_mask;
  logic                    partial;
  logic                    busy;

  doa_event_capture #(
    .NUM_CH (NUM_CH),
    .DLY_W  (DLY_W),
    .WINDOW (W),
    .HOLDOFF(H)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .detected (detected),
    .enable   (enable),
    .doa_valid(doa_valid),
    .doa_ready(doa_ready),
    .first_ch (first_ch),
    .delay    (delay),
    .ch_mask  (ch_mask),
    .partial  (partial),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  first;
    logic [47:0] dly;
    logic [3:0]  mask;
    logic        part;
    int          vld_edge;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_acc = 0;
  int   acc_edge = 0;
  int   rise_edge = 0;
  bit   vld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk_dly(input int d0, input int d1, input int d2, input int d3);
    return {12'(d3), 12'(d2), 12'(d1), 12'(d0)};
  endfunction

  task automatic push(input int first, input int d0, input int d1, input int d2, input int d3,
                      input logic [3:0] mask, input logic part, input int vld_edge);
    rec_t r;
    r.first    = 2'(first);
    r.dly      = mk_dly(d0, d1, d2, d3);
    r.mask     = mask;
    r.part     = part;
    r.vld_edge = vld_edge;
    sb.push_back(r);
  endtask

  // Values visible at a negedge are what the next rising edge samples, hence cyc+1.
  always @(negedge clk) begin
    rec_t e;
    if (doa_valid && !vld_prev) rise_edge = cyc + 1;
    vld_prev = doa_valid;
    if (doa_valid && doa_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_record", 1, 0);
      end else begin
        e = sb.pop_front();
        check("first_ch", first_ch, e.first);
        check("delay", delay, e.dly);
        check("ch_mask", ch_mask, e.mask);
        check("partial", partial, e.part);
        if (e.vld_edge >= 0) check("valid_edge", rise_edge, e.vld_edge);
      end
      acc_edge = cyc + 1;
      n_acc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic wait_accept(input int n0, input int budget);
    for (int i = 0; i < budget && n_acc == n0; i++) tick(1);
    check("accepted", 32'(n_acc != n0), 1);
  endtask

  int c0, c1, a, n0;

  initial begin
    reset_n   = 1'b0;
    detected  = '0;
    enable    = 1'b1;
    doa_ready = 1'b1;
    tick(3);
    check("rst_valid", doa_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_first", first_ch, 0);
    check("rst_delay", delay, 0);
    check("rst_mask", ch_mask, 0);
    check("rst_partial", partial, 0);
    reset_n = 1'b1;
    tick(3);

    // Ordered arrival: ch2, ch0 +3, ch3 +10, ch1 +25
    n0 = n_acc; c0 = cyc;
    push(2, 3, 25, 0, 10, 4'b1111, 1'b0, c0 + 25 + 3);
    detected[2] = 1'b1;
    wait_until(c0 + 3);  detected[0] = 1'b1;
    wait_until(c0 + 10); detected[3] = 1'b1;
    wait_until(c0 + 25); detected[1] = 1'b1;
    wait_accept(n0, 60);
    detected = '0;
    wait_until(acc_edge + H + 5);

    // Simultaneous first arrivals on ch1/ch3, then ch0/ch2 +7
    n0 = n_acc; c0 = cyc;
    push(1, 7, 0, 7, 0, 4'b1111, 1'b0, c0 + 7 + 3);
    detected[1] = 1'b1; detected[3] = 1'b1;
    wait_until(c0 + 7); detected[0] = 1'b1; detected[2] = 1'b1;
    wait_accept(n0, 40);
    detected = '0;
    wait_until(acc_edge + H + 5);

    // Timeout: ch1 exactly at the window edge is still captured
    n0 = n_acc; c0 = cyc;
    push(0, 0, W, NONE, NONE, 4'b0011, 1'b1, c0 + W + 3);
    detected[0] = 1'b1;
    wait_until(c0 + W); detected[1] = 1'b1;
    wait_accept(n0, W + 20);
    detected = '0;
    wait_until(acc_edge + H + 5);

    // Back-pressure for 50 cycles, then hold-off boundary
    doa_ready = 1'b0;
    n0 = n_acc; c0 = cyc;
    push(0, 0, 1, 1, 1, 4'b1111, 1'b0, c0 + 4);
    detected[0] = 1'b1;
    tick(1); detected[3:1] = 3'b111;
    for (int i = 0; i < 40 && !doa_valid; i++) tick(1);
    tick(50);
    check("bp_valid", doa_valid, 1);
    check("bp_delay", delay, mk_dly(0, 1, 1, 1));
    check("bp_first", first_ch, 0);
    check("bp_mask", ch_mask, 4'b1111);
    doa_ready = 1'b1;
    wait_accept(n0, 10);
    a = acc_edge;
    detected = '0;
    wait_until(a + 10); detected[2] = 1'b1; tick(2); detected[2] = 1'b0;
    wait_until(a + 60); detected[3] = 1'b1; tick(2); detected[3] = 1'b0;
    wait_until(a + 90);
    check("hold_busy", busy, 1);
    check("hold_no_valid", doa_valid, 0);
    n0 = n_acc;
    wait_until(a + 99);
    detected[1] = 1'b1;
    push(1, NONE, 0, NONE, NONE, 4'b0010, 1'b1, a + 99 + W + 3);
    tick(1);
    check("idle_after_hold", busy, 0);
    tick(1);
    check("rearm_busy", busy, 1);
    wait_accept(n0, W + 20);
    detected = '0;
    wait_until(acc_edge + H + 5);

    // Level held high on ch0 across the event must not re-trigger
    n0 = n_acc; c0 = cyc;
    push(0, 0, 2, NONE, NONE, 4'b0011, 1'b1, c0 + W + 3);
    detected[0] = 1'b1;
    wait_until(c0 + 2); detected[1] = 1'b1;
    wait_accept(n0, W + 20);
    wait_until(acc_edge + H + 50);
    check("level_no_retrigger", busy, 0);
    detected[0] = 1'b0;
    tick(3);
    n0 = n_acc; c1 = cyc;
    push(0, 0, NONE, NONE, NONE, 4'b0001, 1'b1, c1 + W + 3);
    detected[0] = 1'b1;
    wait_accept(n0, W + 20);
    detected = '0;
    wait_until(acc_edge + H + 5);

    // Enable low in IDLE blocks arming; levels held through re-enable give no rise
    enable = 1'b0;
    detected[2] = 1'b1;
    tick(5);
    check("en_off_busy_a", busy, 0);
    detected[3] = 1'b1;
    tick(5);
    check("en_off_busy_b", busy, 0);
    enable = 1'b1;
    tick(10);
    check("en_on_level_busy", busy, 0);
    detected = '0;
    tick(3);

    // Reset mid-capture aborts the event
    detected[2] = 1'b1;
    tick(5);
    check("cap_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", doa_valid, 0);
    check("abort_first", first_ch, 0);
    check("abort_mask", ch_mask, 0);
    check("abort_delay", delay, 0);
    check("abort_partial", partial, 0);
    detected = '0;
    tick(2);
    reset_n = 1'b1;
    tick(60);
    check("post_abort_busy", busy, 0);

    // All channels already high at reset release: one record, all delays 0
    reset_n = 1'b0;
    detected = 4'hF;
    tick(2);
    reset_n = 1'b1;
    n0 = n_acc;
    push(0, 0, 0, 0, 0, 4'b1111, 1'b0, -1);
    wait_accept(n0, 20);
    detected = '0;
    tick(5);

    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
